conv_writeback: RTL
===================

CONV_WRITEBACK -- requirements
Module: conv_writeback

Interface
REQ-001 SHALL have parameter ACC_W, default 20, width of the signed MAC accumulator result.
REQ-002 SHALL have parameter OUT_W, default 8, width of the signed stored output pixel.
REQ-003 SHALL have parameter ADDR_W, default 10, width of the output memory address.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1: one-cycle job launch; sampled only in IDLE.
REQ-007 SHALL have port base_addr, input, ADDR_W: first output address; latched at start.
REQ-008 SHALL have port count, input, ADDR_W: number of results in the job; latched at start.
REQ-009 SHALL have port shift, input, 4: arithmetic right-shift amount, 0..15; latched at start.
REQ-010 SHALL have port in_valid, input, 1: a MAC result is presented.
REQ-011 SHALL have port in_data, input, ACC_W: signed MAC result.
REQ-012 SHALL have port in_ready, output, 1: the block accepts the result this cycle.
REQ-013 SHALL have port mem_wen, output, 1: output-memory write strobe.
REQ-014 SHALL have port mem_addr, output, ADDR_W: write address.
REQ-015 SHALL have port mem_wdata, output, OUT_W: write data.
REQ-016 SHALL have port busy, output, 1: high in RUN and DRAIN.
REQ-017 SHALL have port done, output, 1: one-cycle pulse when the job completes.

Function
REQ-018 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-019 IDLE to RUN SHALL occur when start is high and count is nonzero; start with count=0 SHALL go directly to DONE, with no writes.
REQ-020 RUN SHALL assert in_ready; a transfer SHALL occur only on in_valid && in_ready.
REQ-021 On the count-th transfer, the FSM SHALL go RUN to DRAIN, and in_ready SHALL be low from the next cycle.
REQ-022 DRAIN to DONE SHALL take one cycle; DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-023 Each accepted result SHALL produce exactly one write: mem_wen high, exactly one cycle after the transfer (latency 1).
REQ-024 The k-th write (k = 0..count-1) SHALL target base_addr+k, modulo 2^ADDR_W; the address wraps silently.
REQ-025 Data path SHALL be in_data >>> shift (arithmetic, floor), saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-026 in_valid gaps during RUN SHALL stall the job without losing the counter or address state.
REQ-027 start while busy SHALL be ignored; in_valid outside RUN SHALL be ignored and SHALL cause no write.
REQ-028 mem_addr and mem_wdata SHALL hold their last values when mem_wen is low.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE, and in_ready, mem_wen, busy and done SHALL be 0; mem_addr, mem_wdata and the counters SHALL be 0.
REQ-030 Reset mid-job SHALL abort the job: no further write, and no done pulse.

Configuration
REQ-031 With CONV_WB_RELU_EN defined, negative shifted values SHALL be written as 0, giving the output range [0, 2^(OUT_W-1)-1].
REQ-032 Without CONV_WB_RELU_EN, signed saturation per REQ-025 SHALL apply; all other behaviour is identical.

Structure
REQ-033 Shared package conv_pkg SHALL hold the ACC_W, OUT_W and ADDR_W defaults and the writeback state enum.
REQ-034 Shift, saturation and optional ReLU SHALL be one combinational sub-module, sat_shift; the FSM, counters and output registers SHALL be in conv_writeback.

Verification
REQ-035 Nominal: base_addr=100, count=3, shift=2, data 40/-40/1000 back-to-back -> writes at 100/101/102 of 10/-10/127; done 1 cycle after the last write.
REQ-036 Wrap and stall: base_addr=1022, count=4, in_valid toggling 1,0,1,0,... -> addresses 1022, 1023, 0, 1; exactly 4 writes.
REQ-037 Zero count: start with count=0 -> done pulses in the next cycle; mem_wen never high; busy never high.
REQ-038 Saturation: shift=0, data -5000 -> -128 (with CONV_WB_RELU_EN: 0); data -3 -> -3 (with CONV_WB_RELU_EN: 0).
REQ-039 Abort: reset asserted after 2 of 5 transfers -> no further mem_wen and no done; a new job then runs normally from its own base_addr.
REQ-040 Ignore: start pulse and in_valid while in DRAIN -> no new job, no extra write, and one done pulse.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared defaults and state encoding for the convolution writeback stage.
package conv_pkg;

  localparam int unsigned ACC_W_DEF  = 20;
  localparam int unsigned OUT_W_DEF  = 8;
  localparam int unsigned ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift of a MAC result followed by clamping to the pixel range.
// Defining CONV_WB_RELU_EN clamps negative results to zero instead of the signed minimum.
module sat_shift
  import conv_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] data_i,
  input  logic [3:0]       shift_i,
  output logic [OUT_W-1:0] data_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (OUT_W - 1)) - 1);
  // Bitwise complement of the maximum is the two's-complement minimum.
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = $signed(data_i) >>> shift_i;
    data_o  = OUT_W'(shifted);
    if (shifted > MAX_V) begin
      data_o = OUT_W'(MAX_V);
`ifdef CONV_WB_RELU_EN
    end else if (shifted[ACC_W-1]) begin
      data_o = '0;
`else
    end else if (shifted < MIN_V) begin
      data_o = OUT_W'(MIN_V);
`endif
    end
  end

endmodule

// File: rtl/conv_writeback.sv
// Writes a job of shifted/saturated MAC results to consecutive output-memory addresses.
// Optional ReLU clamping is selected by CONV_WB_RELU_EN inside sat_shift.
module conv_writeback
  import conv_pkg::*;
#(
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic [3:0]        shift,
  input  logic              in_valid,
  input  logic [ACC_W-1:0]  in_data,
  output logic              in_ready,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OUT_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              done
);

  wb_state_e         state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [3:0]        shift_q;
  logic              in_ready_q, wen_q, busy_q, done_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [OUT_W-1:0]  wdata_q;
  logic [OUT_W-1:0]  sat_data;
  logic              xfer;

  sat_shift #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
    .data_i  (in_data),
    .shift_i (shift_q),
    .data_o  (sat_data)
  );

  // in_ready_q is only ever high in RUN, so it alone qualifies a transfer.
  always_comb begin
    xfer   = in_valid && in_ready_q;
    addr_d = addr_q + ADDR_W'(1);
    cnt_d  = cnt_q - ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      in_ready_q <= 1'b0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      wen_q  <= 1'b0;
      done_q <= 1'b0;
      if (xfer) begin
        wen_q   <= 1'b1;
        maddr_q <= addr_q;
        wdata_q <= sat_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= base_addr;
            cnt_q   <= count;
            shift_q <= shift;
            if (count != '0) begin
              state_q    <= ST_RUN;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            if (cnt_q == ADDR_W'(1)) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_wen   = wen_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
